// File: rtl/blink_ctrl_l.sv
// Blink timing source for the 7-seg "L" decoder: ms prescaler plus IDLE/ON/OFF FSM.
// Optional feature: define BLINK_PAUSE_EN to add the `pause` input that freezes timing.
module blink_ctrl_l #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned ON_MS  = 500,
    parameter int unsigned OFF_MS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] count,
`ifdef BLINK_PAUSE_EN
    input  logic       pause,
`endif
    output logic       en,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DIV    = CLK_HZ / 1000;
    localparam int unsigned PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PH_MAX = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
    localparam int unsigned HW     = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [HW-1:0]   phase_q, phase_d;
    logic [3:0]      blinks_q, blinks_d;
    logic [3:0]      count_q, count_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            hold;

`ifdef BLINK_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign tick = (presc_q == PW'(DIV - 1));

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        phase_d  = phase_q;
        blinks_d = blinks_q;
        count_d  = count_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d  = StOn;
                    count_d  = count;
                    blinks_d = 4'd0;
                end
            end
            StOn, StOff: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (!hold) begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        phase_d = phase_q + 1'b1;
                    end
                    if (state_q == StOn) begin
                        if (tick && phase_q == HW'(ON_MS - 1)) begin
                            state_d = StOff;
                        end
                    end else if (tick && phase_q == HW'(OFF_MS - 1)) begin
                        blinks_d = blinks_q + 1'b1;
                        if (count_q != 4'd0 && blinks_d == count_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StOn;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Every state entry restarts the phase timing from zero.
        if (state_d != state_q) begin
            presc_d = '0;
            phase_d = '0;
        end

        en_d   = (state_d == StOn);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            phase_q  <= '0;
            blinks_q <= 4'd0;
            count_q  <= 4'd0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            phase_q  <= phase_d;
            blinks_q <= blinks_d;
            count_q  <= count_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
